// File: rtl/rain_pkg.sv
// Shared types and defaults for the glyph-rain frame sequencer.
package rain_pkg;

   typedef enum logic [1:0] {
      INTRO   = 2'd0,
      RAIN    = 2'd1,
      PAUSE_I = 2'd2,
      PAUSE_R = 2'd3
   } rain_state_e;

   localparam int FRAME_W_DEF = 10;
   localparam int PAL_W_DEF   = 2;

endpackage

// File: rtl/vsync_edge_detect.sv
// Normalises vsync polarity and produces a one-cycle frame-start pulse on
// the leading edge of the sync pulse.
module vsync_edge_detect #(
   parameter logic VSYNC_ACTIVE = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic vsync,
   output logic fs
);

   logic vs_act;
   logic vs_q;

   assign vs_act = (vsync == VSYNC_ACTIVE);

   // Previous-cycle sync level; resets high so a sync already asserted at
   // reset release is not mistaken for a new frame.
   always_ff @(posedge clk) begin
      if (reset) vs_q <= 1'b1;
      else       vs_q <= vs_act;
   end

   assign fs = vs_act & ~vs_q;

endmodule

// File: rtl/rain_frame_sequencer.sv
// Frame scheduler for the glyph-rain display: frame index, intro drop flag
// and tear-free palette select, all updated at vsync frame start.
//
// state   | meaning
// --------+----------------------------------------------------------
// INTRO   | animating, intro drop phase (first pass through frames)
// RAIN    | animating, steady rain after the first frame wrap
// PAUSE_I | paused during intro; single-step allowed
// PAUSE_R | paused during rain; single-step allowed
module rain_frame_sequencer
   import rain_pkg::*;
#(
   parameter int   FRAME_W      = FRAME_W_DEF,
   parameter int   PAL_W        = PAL_W_DEF,
   parameter logic VSYNC_ACTIVE = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               vsync,
   input  logic               run,
   input  logic               step,
   input  logic [1:0]         speed,
   input  logic [PAL_W-1:0]   pal_req,
   input  logic               pal_req_valid,
   output logic               pal_req_ready,
   output logic [FRAME_W-1:0] frame,
   output logic               drop_active,
   output logic [PAL_W-1:0]   pal_sel,
   output logic               frame_tick,
   output logic [1:0]         state
);

   logic fs;

   vsync_edge_detect #(.VSYNC_ACTIVE(VSYNC_ACTIVE)) u_edge (
      .clk   (clk),
      .reset (reset),
      .vsync (vsync),
      .fs    (fs)
   );

   rain_state_e        state_q, state_nxt;
   logic [FRAME_W-1:0] frame_q, frame_nxt;
   logic [1:0]         div_q, div_nxt;
   logic               tick_q, tick_nxt;
   logic               step_q, step_nxt;
   logic               pend_valid_q, pend_valid_nxt;
   logic [PAL_W-1:0]   pend_data_q, pend_data_nxt;
   logic [PAL_W-1:0]   pal_q, pal_nxt;
   logic               adv_ok;
   logic               adv;
   logic               paused;

   assign paused = (state_q == PAUSE_I) || (state_q == PAUSE_R);

   // Register all sequencer state; reset discards pending step and palette.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= INTRO;
         frame_q      <= '0;
         div_q        <= '0;
         tick_q       <= 1'b0;
         step_q       <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_data_q  <= '0;
         pal_q        <= '0;
      end else begin
         state_q      <= state_nxt;
         frame_q      <= frame_nxt;
         div_q        <= div_nxt;
         tick_q       <= tick_nxt;
         step_q       <= step_nxt;
         pend_valid_q <= pend_valid_nxt;
         pend_data_q  <= pend_data_nxt;
         pal_q        <= pal_nxt;
      end
   end

   // Next-state: divider, run/pause/step FSM, frame advance and palette apply.
   always_comb begin
      state_nxt      = state_q;
      frame_nxt      = frame_q;
      div_nxt        = div_q;
      tick_nxt       = 1'b0;
      step_nxt       = step_q;
      pend_valid_nxt = pend_valid_q;
      pend_data_nxt  = pend_data_q;
      pal_nxt        = pal_q;
      adv_ok         = 1'b0;
      adv            = 1'b0;

      if (fs) begin
         if (div_q == speed) begin
            adv_ok  = 1'b1;
            div_nxt = '0;
         end else begin
            div_nxt = div_q + 2'd1;
         end

         case (state_q)
            INTRO, RAIN: begin
               if (!run) state_nxt = (state_q == INTRO) ? PAUSE_I : PAUSE_R;
               else      adv = adv_ok;
            end
            PAUSE_I, PAUSE_R: begin
               // Resuming behaves like a running frame start, divider included.
               if (run) begin
                  state_nxt = (state_q == PAUSE_I) ? INTRO : RAIN;
                  adv       = adv_ok;
                  step_nxt  = 1'b0;
               end else if (step_q) begin
                  adv      = 1'b1;
                  step_nxt = 1'b0;
               end
            end
            default: state_nxt = INTRO;
         endcase

         if (pend_valid_q) begin
            pal_nxt        = pend_data_q;
            pend_valid_nxt = 1'b0;
         end
      end

      if (adv) begin
         frame_nxt = frame_q + 1'b1;
         tick_nxt  = 1'b1;
         // The first wrap of the frame counter ends the intro phase.
         if (frame_q == '1) begin
            if (state_nxt == INTRO)        state_nxt = RAIN;
            else if (state_nxt == PAUSE_I) state_nxt = PAUSE_R;
         end
      end

      // A step seen on the frame-start cycle itself waits for the next one.
      if (step && paused && !(fs && run)) step_nxt = 1'b1;

      if (pal_req_valid && !pend_valid_q) begin
         pend_valid_nxt = 1'b1;
         pend_data_nxt  = pal_req;
      end
   end

   assign pal_req_ready = ~pend_valid_q;
   assign frame         = frame_q;
   assign drop_active   = (state_q == INTRO) || (state_q == PAUSE_I);
   assign pal_sel       = pal_q;
   assign frame_tick    = tick_q;
   assign state         = state_q;

endmodule

// File: doc/rain_frame_sequencer.md
Name: rain_frame_sequencer

Overview:
Clock-domain frame scheduler for the glyph-rain display. It replaces the vsync-clocked frame counter with logic clocked by clk, and it drives the animation frame index, the intro "drop" phase flag and the palette select into the glyph datapath. It supports run/pause, single-step, a programmable frame-rate divider, and tear-free palette changes through a valid/ready handshake. It sits between the hvsync generator and the glyph/palette pipeline.

Parameters:
FRAME_W, 10, width of the frame counter; wraps modulo 2^FRAME_W.
PAL_W, 2, width of the palette select.
VSYNC_ACTIVE, 1'b0, level of vsync that marks the sync pulse.

Ports:
clk  in  1  pixel clock.
reset  in  1  reset, synchronous, active-high.
vsync  in  1  vertical sync from the hvsync generator, same clock domain.
run  in  1  1 = animate; 0 = pause, sampled at frame start.
step  in  1  1-cycle pulse; requests one advance while paused.
speed  in  2  advance once every speed+1 frame starts.
pal_req  in  PAL_W  requested palette.
pal_req_valid  in  1  palette request valid.
pal_req_ready  out  1  palette request accepted when valid&ready.
frame  out  FRAME_W  animation frame index.
drop_active  out  1  1 during the intro drop phase.
pal_sel  out  PAL_W  applied palette select.
frame_tick  out  1  1-cycle pulse in the first cycle frame shows a new value.
state  out  2  FSM state, for debug.

Behaviour:
- Reset values: frame=0, drop_active=1, pal_sel=0, pal_req_ready=1, frame_tick=0, state=INTRO, divider=0, step_pending=0, pal_pending empty.
- vs_act = (vsync == VSYNC_ACTIVE). vs_q is a registered copy of vs_act and resets to 1, so a vsync already asserted at reset release produces no edge.
- fs (frame start) = vs_act & ~vs_q. fs is combinational in its cycle; all effects are registered and visible the next cycle (latency 1).
- Divider at fs: if div == speed, set adv_ok=1 and div←0; else div←div+1 and adv_ok=0. A speed change takes effect at the next compare.
- States: INTRO(0), RAIN(1), PAUSE_I(2), PAUSE_R(3).
- INTRO and RAIN at fs:
  - If run=0, go to the matching PAUSE state; no advance.
  - Else, if adv_ok, frame←frame+1.
  - In INTRO, an advance from all-ones wraps frame to 0 and moves to RAIN.
  - In RAIN, wrap stays in RAIN.
- PAUSE_x at fs:
  - If run=1, return to INTRO or RAIN; the divider applies normally from that fs.
  - Else, if step_pending, advance exactly one frame (ignores the divider), clear step_pending, and apply the INTRO→RAIN wrap rule. The state stays paused; on that wrap PAUSE_I→PAUSE_R.
- step_pending:
  - Set by step only while in a PAUSE state; multiple pulses before fs collapse to one.
  - step while running is ignored.
  - step and fs in the same cycle: the step applies at the next fs.
- drop_active = 1 in INTRO and PAUSE_I, 0 otherwise (registered with the state).
- frame_tick = 1 for the single cycle after an fs that advanced frame.
- Palette handshake:
  - pal_req_ready = ~pal_pending_valid.
  - On valid&ready, capture pal_req and set pending; ready drops the next cycle.
  - At the next fs, pal_sel←pending and pending clears. This happens in every state, paused included.
  - Acceptance in the same cycle as fs: the capture happens, and it is applied at the following fs, not this one.
  - valid without ready: the requester holds; there is no drop and no overwrite.
- Synchronous reset at any time restores all reset values on the next edge and discards pending step and palette requests.

Decomposition:
- Package rain_pkg: state enum (INTRO, RAIN, PAUSE_I, PAUSE_R), and constants FRAME_W_DEF=10 and PAL_W_DEF=2.
- One sub-module, vsync_edge_detect (polarity normalisation, vs_q register, fs pulse).
- Divider, FSM and palette handshake stay flat in rain_frame_sequencer.

Test Plan:
- Reset, run=1, speed=0, 1024 vsync pulses → frame 0→1023 with one frame_tick each and drop_active=1. The 1024th pulse gives frame=0, drop_active=0, state=RAIN. The 1025th pulse gives frame=1, state still RAIN.
- speed=2, run=1, 9 vsync pulses from reset → frame=3, advancing on the 3rd, 6th and 9th pulses; frame_tick count = 3.
- run=1 until frame=5, then run=0 → state=PAUSE_I and frame holds at 5 over 4 pulses. Two step pulses before one fs → frame=6 only. A step in the same cycle as fs → advance at the following fs.
- pal_req=2, valid for 1 cycle mid-frame → ready=0 next cycle, pal_sel=0 until fs, then pal_sel=2 and ready=1 one cycle after fs. A second request (pal_req=3) while pending stalls with ready=0 and is applied at the fs after that.
- vsync held at the active level across reset release → no fs and no frame_tick until vsync deasserts and reasserts. reset asserted at frame=300 in INTRO with a palette pending → frame=0, state=INTRO, pal_sel=0, ready=1.
- Paused in PAUSE_I at frame=1023, one step → frame=0, state=PAUSE_R, drop_active=0. Then run=1 → state=RAIN.
